// File: rtl/dct_pkg.sv
// Shared definitions for the 4-point forward/inverse integer DCT datapaths:
// FSM states, HEVC basis constants, internal width and arithmetic helpers.
package dct_pkg;

    typedef enum logic [1:0] {
        StCollect,
        StCompute,
        StEmit
    } dct_state_e;

    localparam int unsigned C64   = 64;
    localparam int unsigned C83   = 83;
    localparam int unsigned C36   = 36;
    localparam int unsigned ACC_W = 36;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Constant multiply as a sum of shifted copies; c is always an elaboration constant.
    function automatic acc_t cmul(input acc_t v, input int unsigned c);
        acc_t acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                acc = acc + (v <<< i);
            end
        end
        return acc;
    endfunction

    // Clamp v to the signed range of a w-bit value.
    function automatic acc_t sat_w(input acc_t v, input int unsigned w);
        acc_t hi;
        acc_t lo;
        hi = acc_t'((64'sd1 <<< (w - 1)) - 64'sd1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dct4_butterfly.sv
// Combinational 4-point forward DCT butterfly; even/odd split followed by
// the 64/83/36 basis products, all at full internal width.
module dct4_butterfly
    import dct_pkg::*;
(
    input  acc_t x0,
    input  acc_t x1,
    input  acc_t x2,
    input  acc_t x3,
    output acc_t y0,
    output acc_t y1,
    output acc_t y2,
    output acc_t y3
);

    acc_t e0;
    acc_t o0;
    acc_t e1;
    acc_t o1;

    assign e0 = x0 + x3;
    assign o0 = x0 - x3;
    assign e1 = x1 + x2;
    assign o1 = x1 - x2;

    assign y0 = cmul(e0 + e1, C64);
    assign y1 = cmul(o0, C83) + cmul(o1, C36);
    assign y2 = cmul(e0 - e1, C64);
    assign y3 = cmul(o0, C36) - cmul(o1, C83);

endmodule

// File: rtl/dct4_fwd_stream.sv
// Streaming 4-point forward integer DCT: collects a residual row serially,
// transforms it in one cycle, then emits rounded, saturated coefficients.
module dct4_fwd_stream
    import dct_pkg::*;
#(
    parameter int unsigned SHIFT = 7,
    parameter int unsigned ROUND = 1 << (SHIFT - 1),
    parameter int unsigned W     = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] d_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] d_out,
    output logic [1:0]          out_idx,
    output logic                busy
);

    dct_state_e          state_q;
    dct_state_e          state_d;
    logic [1:0]          in_cnt_q;
    logic [1:0]          in_cnt_d;
    logic [1:0]          out_cnt_q;
    logic [1:0]          out_cnt_d;
    logic signed [W-1:0] x_q [4];
    logic signed [W-1:0] x_d [4];
    acc_t                y_q [4];
    acc_t                y_d [4];

    acc_t bf_y0;
    acc_t bf_y1;
    acc_t bf_y2;
    acc_t bf_y3;

    dct4_butterfly u_butterfly (
        .x0 (acc_t'(x_q[0])),
        .x1 (acc_t'(x_q[1])),
        .x2 (acc_t'(x_q[2])),
        .x3 (acc_t'(x_q[3])),
        .y0 (bf_y0),
        .y1 (bf_y1),
        .y2 (bf_y2),
        .y3 (bf_y3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StCollect;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    x_d[in_cnt_q] = d_in;
                    if (in_cnt_q == 2'd3) begin
                        in_cnt_d = 2'd0;
                        state_d  = StCompute;
                    end else begin
                        in_cnt_d = in_cnt_q + 2'd1;
                    end
                end
            end
            StCompute: begin
                y_d[0]    = bf_y0;
                y_d[1]    = bf_y1;
                y_d[2]    = bf_y2;
                y_d[3]    = bf_y3;
                out_cnt_d = 2'd0;
                state_d   = StEmit;
            end
            StEmit: begin
                if (out_ready) begin
                    if (out_cnt_q == 2'd3) begin
                        out_cnt_d = 2'd0;
                        state_d   = StCollect;
                    end else begin
                        out_cnt_d = out_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    acc_t                y_sel;
    acc_t                coef_rnd;
    acc_t                coef_sat;
    logic signed [W-1:0] coef_w;

    // Output is a pure function of registered state, so it holds under backpressure.
    assign y_sel    = y_q[out_cnt_q];
    assign coef_rnd = (y_sel + acc_t'(ROUND)) >>> SHIFT;
    assign coef_sat = sat_w(coef_rnd, W);
    assign coef_w   = W'(coef_sat);

    assign in_ready  = (state_q == StCollect);
    assign out_valid = (state_q == StEmit);
    assign d_out     = out_valid ? coef_w : '0;
    assign out_idx   = out_valid ? out_cnt_q : 2'd0;
    assign busy      = !((state_q == StCollect) && (in_cnt_q == 2'd0));

endmodule
